// File: rtl/refill_pkg.sv
// Shared types for the cache refill arbiter: FSM states, transfer owner, counter width helper.
package refill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Word-index width for a line of the given size; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/refill_arbiter_rr_arb2.sv
// Two-way round-robin pick between I-cache and D-cache refill requests.
module rr_arb2
  import refill_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  owner_e last_i,
  output logic   valid_o,
  output owner_e gnt_o
);

  // On a tie the side that was not served last wins.
  always_comb begin
    valid_o = i_req_i | d_req_i;
    gnt_o   = OWN_I;
    if (d_req_i && (!i_req_i || (last_i == OWN_I))) begin
      gnt_o = OWN_D;
    end
  end

endmodule

// File: rtl/refill_arbiter.sv
// Shares one memory port between I-cache and D-cache line refills, with optional
// D-cache victim writeback ahead of the fill, and raises the pipeline stall.
module refill_arbiter
  import refill_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_req,
  input  logic [ADDR_W-1:0]                 i_addr,
  output logic                              i_rvalid,
  output logic                              i_done,
  input  logic                              d_req,
  input  logic [ADDR_W-1:0]                 d_addr,
  input  logic                              d_dirty,
  input  logic [ADDR_W-1:0]                 d_wb_addr,
  input  logic [DATA_W-1:0]                 d_wb_data,
  output logic                              d_rvalid,
  output logic                              d_done,
  output logic [cnt_w(LINE_WORDS)-1:0]      fill_idx,
  output logic [DATA_W-1:0]                 fill_data,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  input  logic                              mem_ack,
  output logic                              miss
);

  localparam int unsigned CNT_W  = cnt_w(LINE_WORDS);
  localparam int unsigned LINE_W = ADDR_W - CNT_W - 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic              gnt_valid;
  owner_e            gnt;
  logic              last_beat;
  logic              unused_offset;

  // Line-offset bits of the incoming addresses are replaced by the word counter.
  assign unused_offset = ^{i_addr[CNT_W+1:0], d_addr[CNT_W+1:0], d_wb_addr[CNT_W+1:0]};
  assign last_beat     = mem_ack && (cnt_q == CNT_LAST);

  rr_arb2 u_rr (
    .i_req_i (i_req),
    .d_req_i (d_req),
    .last_i  (last_q),
    .valid_o (gnt_valid),
    .gnt_o   (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      line_q  <= '0;
      owner_q <= OWN_I;
      last_q  <= OWN_I;
    end else begin
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next state plus counter, line base and owner bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt;
          if (gnt == OWN_D) begin
            line_d  = d_dirty ? d_wb_addr[ADDR_W-1:CNT_W+2] : d_addr[ADDR_W-1:CNT_W+2];
            state_d = d_dirty ? WB : FILL;
          end else begin
            line_d  = i_addr[ADDR_W-1:CNT_W+2];
            state_d = FILL;
          end
        end
      end
      WB: begin
        if (mem_ack) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (last_beat) begin
          line_d  = d_addr[ADDR_W-1:CNT_W+2];
          state_d = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (last_beat) begin
          last_d  = owner_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port, fill strobes and stall decode.
  always_comb begin
    mem_req   = (state_q == WB) || (state_q == FILL);
    mem_we    = (state_q == WB);
    mem_addr  = mem_req ? {line_q, cnt_q, 2'b00} : '0;
    mem_wdata = (state_q == WB) ? d_wb_data : '0;
    i_rvalid  = (state_q == FILL) && (owner_q == OWN_I) && mem_ack;
    d_rvalid  = (state_q == FILL) && (owner_q == OWN_D) && mem_ack;
    i_done    = (state_q == DONE) && (owner_q == OWN_I);
    d_done    = (state_q == DONE) && (owner_q == OWN_D);
    fill_idx  = cnt_q;
    fill_data = mem_rdata;
    miss      = !rst && ((i_req && !i_done) || (d_req && !d_done) || mem_req);
  end

endmodule
